ps2_mouse_tracker: RTL and testbench

- Receive-only PS/2 mouse front end that produces the cursor inputs consumed by the game logic: mouseX, mouseY, mouseBotton.
- Deserializes 11-bit device-to-host frames and assembles 3-byte stream-mode packets.
- Accumulates the signed deltas into a clamped screen position for the 640x480 display.
- Stream-mode enable (0xF4) is issued by a separate host-transmit block; this block never drives the PS/2 lines.

---
 rtl/ps2_mouse_tracker.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// Receive-only PS/2 mouse front end: conditions the raw lines, deframes bytes,
// assembles 3-byte stream packets and integrates deltas into a clamped cursor.
module ps2_mouse_tracker #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mouseX,
  output logic [9:0] mouseY,
  output logic       mouseBotton,
  output logic       mouseRight,
  output logic       mouseMiddle,
  output logic       pkt_valid,
  output logic       frame_err,
  output logic [1:0] frame_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam logic signed [11:0] X_LIM = X_MAX[11:0];
  localparam logic signed [11:0] Y_LIM = Y_MAX[11:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchronizers and clock glitch filter
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      if (clk_s2 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FILT_LAST) begin
        clk_filt <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // The filtered clock drops in the same cycle this is high.
  assign fall = clk_filt & ~clk_s2 & (flt_cnt == FILT_LAST);

  // Frame, packet and cursor state
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic [1:0]    byte_idx;
  logic [6:0]    hdr;      // {Yovf, Xovf, Ysign, Xsign, M, R, L}
  logic [7:0]    dx_byte;
  logic [7:0]    dy_byte;
  logic          upd_pend;
  logic [TW-1:0] timer;

  logic signed [11:0] dx, dy, sx, sy;
  logic [9:0]         nx, ny;

  always_comb begin
    dx = '0;
    dy = '0;
    if (!hdr[5]) dx = {{3{hdr[3]}}, hdr[3], dx_byte};
    if (!hdr[6]) dy = {{3{hdr[4]}}, hdr[4], dy_byte};
    sx = $signed({2'b00, mouseX}) + dx;
    // Mouse Y grows upward, screen Y grows downward.
    sy = $signed({2'b00, mouseY}) - dy;
    nx = sx[9:0];
    ny = sy[9:0];
    if (sx < 12'sd0)     nx = '0;
    else if (sx > X_LIM) nx = X_LIM[9:0];
    if (sy < 12'sd0)     ny = '0;
    else if (sy > Y_LIM) ny = Y_LIM[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_ok      <= 1'b0;
      byte_idx    <= '0;
      hdr         <= '0;
      dx_byte     <= '0;
      dy_byte     <= '0;
      upd_pend    <= 1'b0;
      timer       <= '0;
      mouseX      <= X_INIT[9:0];
      mouseY      <= Y_INIT[9:0];
      mouseBotton <= 1'b0;
      mouseRight  <= 1'b0;
      mouseMiddle <= 1'b0;
      pkt_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      upd_pend  <= 1'b0;

      if (upd_pend) begin
        mouseX      <= nx;
        mouseY      <= ny;
        mouseBotton <= hdr[0];
        mouseRight  <= hdr[1];
        mouseMiddle <= hdr[2];
        pkt_valid   <= 1'b1;
      end

      if (fall) timer <= '0;
      else if (timer != TO_LIMIT) timer <= timer + TW'(1);

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= SHIFT;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          SHIFT: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= (^shreg) ^ data_s2;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_s2 && par_ok) begin
              case (byte_idx)
                2'd0: begin
                  // Bit 3 is always set in a header; anything else means we are out of sync.
                  if (shreg[3]) begin
                    hdr      <= {shreg[7:4], shreg[2:0]};
                    byte_idx <= 2'd1;
                  end else begin
                    frame_err <= 1'b1;
                  end
                end
                2'd1: begin
                  dx_byte  <= shreg;
                  byte_idx <= 2'd2;
                end
                2'd2: begin
                  dy_byte  <= shreg;
                  byte_idx <= 2'd0;
                  upd_pend <= 1'b1;
                end
                default: byte_idx <= 2'd0;
              endcase
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= 2'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timer == TO_LIMIT && (state != IDLE || byte_idx != 2'd0)) begin
        state     <= IDLE;
        byte_idx  <= 2'd0;
        frame_err <= 1'b1;
        timer     <= '0;
      end
    end
  end

  assign frame_state = state;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed and randomized PS/2 packet stimulus against a cursor model built
// from plain integer arithmetic; results scored through an expected queue.
module tb_ps2_mouse_tracker;

  localparam int HALF = 12;
  localparam int TO   = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mouseX, mouseY;
  logic       mouseBotton, mouseRight, mouseMiddle;
  logic       pkt_valid, frame_err;
  logic [1:0] frame_state;

  always #20 clk = ~clk;

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouseX(mouseX), .mouseY(mouseY), .mouseBotton(mouseBotton),
    .mouseRight(mouseRight), .mouseMiddle(mouseMiddle),
    .pkt_valid(pkt_valid), .frame_err(frame_err), .frame_state(frame_state)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int pkt_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Event monitor: counts every cycle each pulse is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_valid) pkt_cnt++;
      if (frame_err) err_cnt++;
      if (pkt_valid && frame_err) both_cnt++;
    end
  end

  // Reference cursor model and scoreboard
  int mx, my;
  logic [2:0] mbtn;
  logic [22:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic model_reset();
    mx = 320;
    my = 240;
    mbtn = 3'b000;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    mx = mx + dx;
    my = my - dy;
    if (mx < 0) mx = 0;
    if (mx > 639) mx = 639;
    if (my < 0) my = 0;
    if (my > 479) my = 479;
    mbtn = b0[2:0];
    exp_q.push_back({mx[9:0], my[9:0], mbtn});
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(3 * HALF);
  endtask

  task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
    int p0, e0, n;
    logic [22:0] e;
    p0 = pkt_cnt;
    e0 = err_cnt;
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    model_apply(b0, b1, b2);
    n = 0;
    while (pkt_cnt == p0 && n < 200) begin
      wait_clk(1);
      n++;
    end
    wait_clk(4);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, " pkt_valid pulses"}, pkt_cnt - p0, 1);
    check({tag, " frame_err pulses"}, err_cnt - e0, 0);
    check({tag, " mouseX"}, mouseX, e[22:13]);
    check({tag, " mouseY"}, mouseY, e[12:3]);
    check({tag, " buttons"}, {mouseMiddle, mouseRight, mouseBotton}, e[2:0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    @(negedge clk);
    check("reset mouseX", mouseX, 320);
    check("reset mouseY", mouseY, 240);
    check("reset buttons", {mouseMiddle, mouseRight, mouseBotton}, 0);
    check("reset pulses", {pkt_valid, frame_err}, 0);
    rst_n = 1'b1;
    model_reset();
    wait_clk(16);
  endtask

  initial begin
    int p0, e0;
    logic [7:0] r0, r1, r2;
    model_reset();

    // Basic movement from reset
    do_reset();
    send_packet("move1", 8'h08, 8'h0A, 8'h05);
    send_packet("move2", 8'h08, 8'h0A, 8'h05);
    send_packet("move3", 8'h08, 8'h0A, 8'h05);

    // Left button with negative dx
    do_reset();
    send_packet("left_neg", 8'h19, 8'hF6, 8'h00);

    // Saturation on both axes
    do_reset();
    for (int i = 0; i < 3; i++) send_packet($sformatf("clamp_x%0d", i), 8'h08, 8'h7F, 8'h00);
    send_packet("neg128", 8'h38, 8'h80, 8'h80);
    for (int i = 0; i < 4; i++) send_packet($sformatf("clamp_y%0d", i), 8'h08, 8'h00, 8'h7F);

    // Overflow bit suppresses the X delta only
    send_packet("xovf", 8'h48, 8'h50, 8'h20);

    // Bad parity frame, then recovery
    p0 = pkt_cnt;
    e0 = err_cnt;
    send_byte(8'h0A, 1'b1);
    wait_clk(20);
    check("bad_parity frame_err", err_cnt - e0, 1);
    check("bad_parity no pkt", pkt_cnt - p0, 0);
    send_packet("after_parity", 8'h08, 8'h0A, 8'h05);

    // Header without bit3 is rejected, next header resyncs
    e0 = err_cnt;
    send_byte(8'h00, 1'b0);
    wait_clk(20);
    check("no_bit3 frame_err", err_cnt - e0, 1);
    send_packet("resync", 8'h09, 8'h03, 8'hFD);

    // Abandoned packet times out exactly once
    p0 = pkt_cnt;
    e0 = err_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b0);
    wait_clk(TO + 200);
    @(negedge clk);
    check("timeout frame_err", err_cnt - e0, 1);
    check("timeout no pkt", pkt_cnt - p0, 0);
    check("timeout mouseX held", mouseX, mx);
    check("timeout mouseY held", mouseY, my);
    wait_clk(TO + 200);
    check("timeout no repeat", err_cnt - e0, 1);
    send_packet("after_timeout", 8'h0A, 8'h20, 8'h10);

    // Reset asserted in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset mouseX", mouseX, 320);
    check("midreset mouseY", mouseY, 240);
    check("midreset buttons", {mouseMiddle, mouseRight, mouseBotton}, 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    model_reset();
    wait_clk(16);
    send_packet("after_midreset", 8'h08, 8'h0A, 8'h05);

    // Randomized packets
    for (int i = 0; i < 15; i++) begin
      r0 = 8'($urandom_range(0, 255)) | 8'h08;
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      send_packet($sformatf("rand%0d", i), r0, r1, r2);
    end

    check("pkt_valid/frame_err overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
